// File: rtl/qs_pkg.sv
// Shared types for the qs sorter: index/range types, the scheduler state
// encoding and a range helper.
package qs_pkg;

  localparam int N  = 16;
  localparam int AW = $clog2(N);
  localparam int W  = 2 * AW;

  typedef logic [AW-1:0] addr_t;
  typedef logic [AW:0]   addr_ext_t;

  // Stack word layout: lo in the MSBs, hi in the LSBs.
  typedef struct packed {
    addr_t lo;
    addr_t hi;
  } range_t;

  typedef enum logic [3:0] {
    S_IDLE,
    S_PUSH,
    S_POP,
    S_POP_WAIT,
    S_ISSUE,
    S_WAIT_RES,
    S_SPLIT,
    S_DONE,
    S_ERR
  } ctrl_state_t;

  // A range needs partitioning only when it holds at least two elements.
  function automatic logic range_valid(input addr_t lo, input addr_t hi);
    return addr_ext_t'(hi) >= (addr_ext_t'(lo) + addr_ext_t'(1));
  endfunction

endpackage

// File: rtl/qs_srt_ctrl.sv
// Quicksort range scheduler: pops ranges from the attached stack, issues them
// to the partition unit and pushes back the sub-ranges around each pivot.
module qs_srt_ctrl
  import qs_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          start_vld,
  input  logic [AW-1:0] start_lo,
  input  logic [AW-1:0] start_hi,
  output logic          start_rdy,
  output logic          job_vld_r,
  output logic [AW-1:0] job_lo_r,
  output logic [AW-1:0] job_hi_r,
  input  logic          job_rdy,
  input  logic          res_vld,
  input  logic [AW-1:0] res_pivot,
  output logic          stk_cmd_vld_r,
  output logic          stk_cmd_push_r,
  output logic [W-1:0]  stk_cmd_push_dat_r,
  output logic          stk_cmd_clr_r,
  input  logic [W-1:0]  stk_head_r,
  input  logic          stk_head_vld_r,
  input  logic          stk_cmd_err_w,
  input  logic          stk_empty_w,
  input  logic          stk_full_w,
  output logic          done_r,
  output logic          err_r,
  output ctrl_state_t   state_o
);

  // Handshakes: job_vld_r/job_rdy is valid/ready -- once raised, job_vld_r and
  // job_lo_r/job_hi_r hold until the cycle job_rdy is seen high, then drop.
  // Stack commands are single-cycle pulses; at most one is ever in flight.

  ctrl_state_t   state_q, state_d;
  logic          job_vld_q, job_vld_d;
  addr_t         job_lo_q, job_lo_d, job_hi_q, job_hi_d;
  addr_t         piv_q, piv_d;
  logic          cmd_vld_q, cmd_vld_d, cmd_push_q, cmd_push_d;
  logic [W-1:0]  cmd_dat_q, cmd_dat_d;
  logic          clr_q, clr_d, done_q, done_d, err_q, err_d;

  range_t        head, left_rng, right_rng, push_dat;
  addr_ext_t     lo_x, hi_x, p_x;
  logic          left_ok, right_ok, push_req, go_err;

  assign head      = stk_head_r;
  assign lo_x      = addr_ext_t'(job_lo_q);
  assign hi_x      = addr_ext_t'(job_hi_q);
  assign p_x       = addr_ext_t'(piv_q);
  // Widened compares keep p=0 and p=N-1 from wrapping.
  assign left_ok   = p_x >= (lo_x + addr_ext_t'(2));
  assign right_ok  = hi_x >= (p_x + addr_ext_t'(2));
  assign left_rng  = '{lo: job_lo_q, hi: piv_q - addr_t'(1)};
  assign right_rng = '{lo: piv_q + addr_t'(1), hi: job_hi_q};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      job_vld_q  <= 1'b0;
      job_lo_q   <= '0;
      job_hi_q   <= '0;
      piv_q      <= '0;
      cmd_vld_q  <= 1'b0;
      cmd_push_q <= 1'b0;
      cmd_dat_q  <= '0;
      clr_q      <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      job_vld_q  <= job_vld_d;
      job_lo_q   <= job_lo_d;
      job_hi_q   <= job_hi_d;
      piv_q      <= piv_d;
      cmd_vld_q  <= cmd_vld_d;
      cmd_push_q <= cmd_push_d;
      cmd_dat_q  <= cmd_dat_d;
      clr_q      <= clr_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    job_vld_d  = job_vld_q;
    job_lo_d   = job_lo_q;
    job_hi_d   = job_hi_q;
    piv_d      = piv_q;
    cmd_vld_d  = 1'b0;
    cmd_push_d = cmd_push_q;
    cmd_dat_d  = cmd_dat_q;
    clr_d      = 1'b0;
    done_d     = 1'b0;
    err_d      = err_q;
    push_req   = 1'b0;
    push_dat   = '0;
    go_err     = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start_vld) begin
          err_d = 1'b0;
          if (!range_valid(start_lo, start_hi)) begin
            done_d  = 1'b1;
            state_d = S_DONE;
          end else begin
            push_req = 1'b1;
            push_dat = '{lo: start_lo, hi: start_hi};
            state_d  = S_POP;
          end
        end
      end
      S_POP: begin
        // Wait out a push still in flight so stk_empty_w is settled.
        if (!cmd_vld_q) begin
          if (stk_empty_w) begin
            done_d  = 1'b1;
            state_d = S_DONE;
          end else begin
            cmd_vld_d  = 1'b1;
            cmd_push_d = 1'b0;
            state_d    = S_POP_WAIT;
          end
        end
      end
      S_POP_WAIT: begin
        if (stk_head_vld_r) begin
          job_lo_d  = head.lo;
          job_hi_d  = head.hi;
          job_vld_d = 1'b1;
          state_d   = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (job_rdy) begin
          job_vld_d = 1'b0;
          state_d   = S_WAIT_RES;
        end
      end
      S_WAIT_RES: begin
        if (res_vld) begin
          piv_d   = res_pivot;
          state_d = S_SPLIT;
        end
      end
      S_SPLIT: begin
        // Right goes in first so the left range is popped next.
        if (right_ok) begin
          push_req = 1'b1;
          push_dat = right_rng;
          state_d  = left_ok ? S_PUSH : S_POP;
        end else if (left_ok) begin
          push_req = 1'b1;
          push_dat = left_rng;
          state_d  = S_POP;
        end else begin
          state_d = S_POP;
        end
      end
      S_PUSH: begin
        push_req = 1'b1;
        push_dat = left_rng;
        state_d  = S_POP;
      end
      S_DONE:  state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (push_req) begin
      if (stk_full_w) begin
        go_err = 1'b1;
      end else begin
        cmd_vld_d  = 1'b1;
        cmd_push_d = 1'b1;
        cmd_dat_d  = push_dat;
      end
    end

    if (go_err || (stk_cmd_err_w && state_q != S_ERR)) begin
      state_d   = S_ERR;
      err_d     = 1'b1;
      clr_d     = 1'b1;
      cmd_vld_d = 1'b0;
      job_vld_d = 1'b0;
      done_d    = 1'b0;
    end
  end

  assign start_rdy          = (state_q == S_IDLE);
  assign job_vld_r          = job_vld_q;
  assign job_lo_r           = job_lo_q;
  assign job_hi_r           = job_hi_q;
  assign stk_cmd_vld_r      = cmd_vld_q;
  assign stk_cmd_push_r     = cmd_push_q;
  assign stk_cmd_push_dat_r = cmd_dat_q;
  assign stk_cmd_clr_r      = clr_q;
  assign done_r             = done_q;
  assign err_r              = err_q;
  assign state_o            = state_q;

endmodule

// File: tb/tb_qs_srt_ctrl.sv
// Directed bench for qs_srt_ctrl with a behavioural range stack beside it.
module tb_qs_srt_ctrl;
  import qs_pkg::*;

  logic          clk, rst;
  logic          start_vld, start_rdy;
  logic [AW-1:0] start_lo, start_hi;
  logic          job_vld_r, job_rdy, res_vld;
  logic [AW-1:0] job_lo_r, job_hi_r, res_pivot;
  logic          stk_cmd_vld_r, stk_cmd_push_r, stk_cmd_clr_r;
  logic [W-1:0]  stk_cmd_push_dat_r, stk_head_r;
  logic          stk_head_vld_r, stk_cmd_err_w, stk_empty_w, stk_full_w;
  logic          done_r, err_r;
  ctrl_state_t   dbg_state;

  qs_srt_ctrl dut (
    .clk(clk), .rst(rst),
    .start_vld(start_vld), .start_lo(start_lo), .start_hi(start_hi), .start_rdy(start_rdy),
    .job_vld_r(job_vld_r), .job_lo_r(job_lo_r), .job_hi_r(job_hi_r), .job_rdy(job_rdy),
    .res_vld(res_vld), .res_pivot(res_pivot),
    .stk_cmd_vld_r(stk_cmd_vld_r), .stk_cmd_push_r(stk_cmd_push_r),
    .stk_cmd_push_dat_r(stk_cmd_push_dat_r), .stk_cmd_clr_r(stk_cmd_clr_r),
    .stk_head_r(stk_head_r), .stk_head_vld_r(stk_head_vld_r),
    .stk_cmd_err_w(stk_cmd_err_w), .stk_empty_w(stk_empty_w), .stk_full_w(stk_full_w),
    .done_r(done_r), .err_r(err_r), .state_o(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // behavioural stack: command seen one edge after issue, head two edges later
  int            depth_lim;
  logic [W-1:0]  stk_q[$];
  int            cnt, cnt_nx;
  logic          s1, ovf;
  logic [W-1:0]  s1_dat;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      stk_q.delete();
      cnt <= 0; s1 <= 1'b0; s1_dat <= '0; ovf <= 1'b0;
      stk_head_vld_r <= 1'b0; stk_head_r <= '0;
    end else begin
      s1 <= 1'b0;
      stk_head_vld_r <= s1;
      stk_head_r <= s1_dat;
      if (stk_cmd_clr_r) begin
        stk_q.delete();
        cnt <= 0;
      end else if (stk_cmd_vld_r) begin
        if (stk_cmd_push_r) begin
          if (stk_q.size() >= depth_lim) ovf <= 1'b1;
          else begin
            stk_q.push_back(stk_cmd_push_dat_r);
            cnt <= cnt + 1;
          end
        end else if (stk_q.size() > 0) begin
          s1_dat <= stk_q.pop_back();
          s1 <= 1'b1;
          cnt <= cnt - 1;
        end
      end
    end
  end

  assign cnt_nx = cnt + ((stk_cmd_vld_r && stk_cmd_push_r) ? 1 : 0)
                      - ((stk_cmd_vld_r && !stk_cmd_push_r) ? 1 : 0);
  assign stk_empty_w = (cnt_nx == 0);
  assign stk_full_w  = (cnt_nx >= depth_lim);

  // event monitors
  logic [W-1:0] push_log[$];
  int job_cnt, done_cnt, cmd_cnt;
  initial begin job_cnt = 0; done_cnt = 0; cmd_cnt = 0; end
  always @(posedge clk) begin
    if (!rst) begin
      if (stk_cmd_vld_r && stk_cmd_push_r) push_log.push_back(stk_cmd_push_dat_r);
      if (stk_cmd_vld_r) cmd_cnt++;
      if (job_vld_r && job_rdy) job_cnt++;
      if (done_r) done_cnt++;
    end
  end

  // scoreboard
  logic [W-1:0] exp_q[$];
  int passed, total;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) passed++;
    else $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  task automatic chk_pushes(input string tag, input int base);
    chk({tag, "_n"}, push_log.size() - base, exp_q.size());
    foreach (exp_q[i]) begin
      chk({tag, "_d"}, (base + i < push_log.size()) ? {24'h0, push_log[base + i]} : 32'hFFFF_FFFF,
          {24'h0, exp_q[i]});
    end
    exp_q.delete();
  endtask

  function automatic logic [31:0] out_vec();
    return {10'h0, job_vld_r, job_lo_r, job_hi_r, stk_cmd_vld_r, stk_cmd_push_r,
            stk_cmd_push_dat_r, stk_cmd_clr_r, done_r, err_r};
  endfunction

  // driver tasks
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic start(input int lo, input int hi);
    start_lo = addr_t'(lo); start_hi = addr_t'(hi); start_vld = 1'b1;
    tick();
    start_vld = 1'b0;
  endtask

  task automatic wait_job(input string tag, input int lo, input int hi);
    int n = 0;
    while (!job_vld_r && n < 100) begin tick(); n++; end
    chk(tag, {29'h0, job_vld_r, 2'b00} | {24'h0, job_lo_r, job_hi_r} | 32'h0,
        {29'h0, 1'b1, 2'b00} | {24'h0, addr_t'(lo), addr_t'(hi)});
  endtask

  task automatic take_job();
    job_rdy = 1'b1;
    tick();
    job_rdy = 1'b0;
  endtask

  task automatic give_res(input int p);
    res_pivot = addr_t'(p); res_vld = 1'b1;
    tick();
    res_vld = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (!done_r && n < 100) begin tick(); n++; end
    chk(tag, {31'h0, done_r}, 32'h1);
  endtask

  int b_job, b_cmd, b_push, b_done, n;

  initial begin
    passed = 0; total = 0; depth_lim = 16;
    rst = 1'b1; start_vld = 1'b0; start_lo = '0; start_hi = '0;
    job_rdy = 1'b0; res_vld = 1'b0; res_pivot = '0; stk_cmd_err_w = 1'b0;
    repeat (2) tick();
    chk("rst_outs", out_vec(), 32'h0);
    chk("rst_state", {28'h0, dbg_state}, {28'h0, S_IDLE});
    rst = 1'b0;
    tick();
    chk("rst_start_rdy", {31'h0, start_rdy}, 32'h1);

    // single-element range completes without a job or stack command
    b_job = job_cnt; b_cmd = cmd_cnt;
    start(3, 3);
    chk("single_done", {31'h0, done_r}, 32'h1);
    tick();
    chk("single_done_pulse", {31'h0, done_r}, 32'h0);
    chk("single_no_job", job_cnt - b_job, 0);
    chk("single_no_cmd", cmd_cnt - b_cmd, 0);

    // 0..7 with pivot 3: right [4,7] pushed before left [0,2]
    b_job = job_cnt; b_push = push_log.size(); b_done = done_cnt;
    start(0, 7);
    wait_job("p3_job07", 0, 7);
    take_job();
    chk("p3_vld_drop", {31'h0, job_vld_r}, 32'h0);
    give_res(3);
    wait_job("p3_job02", 0, 2);
    take_job(); give_res(1);
    wait_job("p3_job47", 4, 7);
    take_job(); give_res(5);
    wait_job("p3_job67", 6, 7);
    take_job(); give_res(6);
    wait_done("p3_done");
    exp_q.push_back(8'h07); exp_q.push_back(8'h47);
    exp_q.push_back(8'h02); exp_q.push_back(8'h67);
    chk_pushes("p3_push", b_push);
    chk("p3_jobs", job_cnt - b_job, 4);
    tick();
    chk("p3_one_done", done_cnt - b_done, 1);

    // pivots at the range edges: only one side is pushed each time
    b_push = push_log.size();
    start(0, 7);
    wait_job("edge_job07", 0, 7);
    take_job(); give_res(0);
    wait_job("edge_job17", 1, 7);
    take_job(); give_res(7);
    wait_job("edge_job16", 1, 6);
    exp_q.push_back(8'h07); exp_q.push_back(8'h17); exp_q.push_back(8'h16);
    chk_pushes("edge_push", b_push);
    do_reset();

    // back-pressure on the job port
    start(0, 1);
    wait_job("stall_job", 0, 1);
    b_job = job_cnt;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_hold", {23'h0, job_vld_r, job_lo_r, job_hi_r}, {23'h0, 1'b1, 4'd0, 4'd1});
    end
    chk("stall_none", job_cnt - b_job, 0);
    take_job();
    chk("stall_one", job_cnt - b_job, 1);
    give_res(0);
    wait_done("stall_done");

    // two-deep stack overflows on the third outstanding push
    do_reset();
    depth_lim = 2;
    b_push = push_log.size(); b_done = done_cnt;
    start(0, 15);
    wait_job("full_job0f", 0, 15);
    take_job(); give_res(7);
    wait_job("full_job06", 0, 6);
    take_job(); give_res(3);
    n = 0;
    while (!stk_cmd_clr_r && n < 50) begin tick(); n++; end
    chk("full_clr", {31'h0, stk_cmd_clr_r}, 32'h1);
    chk("full_err", {31'h0, err_r}, 32'h1);
    chk("full_state", {28'h0, dbg_state}, {28'h0, S_ERR});
    chk("full_no_ovf", {31'h0, ovf}, 32'h0);
    tick();
    chk("full_clr_pulse", {31'h0, stk_cmd_clr_r}, 32'h0);
    chk("full_idle", {31'h0, start_rdy}, 32'h1);
    chk("full_err_sticky", {31'h0, err_r}, 32'h1);
    chk("full_no_done", done_cnt - b_done, 0);
    exp_q.push_back(8'h0F); exp_q.push_back(8'h8F);
    exp_q.push_back(8'h06); exp_q.push_back(8'h46);
    chk_pushes("full_push", b_push);
    depth_lim = 16;
    start(5, 5);
    chk("err_cleared", {31'h0, err_r}, 32'h0);
    tick();

    // stack command error while a job is offered
    start(0, 3);
    wait_job("cerr_job", 0, 3);
    stk_cmd_err_w = 1'b1;
    tick();
    stk_cmd_err_w = 1'b0;
    chk("cerr_flags", {29'h0, stk_cmd_clr_r, err_r, job_vld_r}, {29'h0, 3'b110});
    tick();
    chk("cerr_idle", {31'h0, start_rdy}, 32'h1);

    // asynchronous reset while waiting for a partition result
    start(0, 3);
    chk("cerr_err_clr", {31'h0, err_r}, 32'h0);
    wait_job("ar_job", 0, 3);
    take_job();
    chk("ar_wait_res", {28'h0, dbg_state}, {28'h0, S_WAIT_RES});
    rst = 1'b1;
    #1;
    chk("ar_outs", out_vec(), 32'h0);
    chk("ar_state", {28'h0, dbg_state}, {28'h0, S_IDLE});
    tick();
    rst = 1'b0;
    tick();
    b_job = job_cnt; b_done = done_cnt;
    start(0, 1);
    wait_job("ar_job01", 0, 1);
    take_job(); give_res(1);
    wait_done("ar_done");
    tick();
    chk("ar_jobs", job_cnt - b_job, 1);
    chk("ar_one_done", done_cnt - b_done, 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/qs_srt_ctrl.md
Name: qs_srt_ctrl

Overview:
- Quicksort range scheduler for the qs sorter.
- Sits directly upstream of the qs_srt_stack instance and drives its command port. It pushes and pops packed {lo,hi} ranges.
- Issues each popped range as a job to the partition unit, then splits the returned pivot into sub-ranges.
- Completes when the stack drains empty with no job outstanding.

Parameters:
N, 16, number of sortable elements; index width AW = $clog2(N)
STACK_N, 16, depth of the attached stack; STACK_N is used only by the bench to exercise full conditions
W, 2*AW, stack word width, packed {lo[AW-1:0], hi[AW-1:0]} with lo in the MSBs

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
start_vld  in  1  start request
start_lo  in  AW  initial low index
start_hi  in  AW  initial high index
start_rdy  out  1  high only in IDLE
job_vld_r  out  1  partition job valid
job_lo_r  out  AW  job low index
job_hi_r  out  AW  job high index
job_rdy  in  1  partition unit accepts job
res_vld  in  1  partition result valid, one-cycle pulse
res_pivot  in  AW  final pivot index, lo<=pivot<=hi
stk_cmd_vld_r  out  1  stack command valid
stk_cmd_push_r  out  1  1=push, 0=pop
stk_cmd_push_dat_r  out  W  push data
stk_cmd_clr_r  out  1  stack clear
stk_head_r  in  W  popped data
stk_head_vld_r  in  1  popped data valid
stk_cmd_err_w  in  1  stack command error
stk_empty_w  in  1  stack empty (next-state)
stk_full_w  in  1  stack full (next-state)
done_r  out  1  one-cycle completion pulse
err_r  out  1  sticky error, cleared on next accepted start

Behaviour:
- Interface: one clock, clk; reset rst is asynchronous and active-high.
- Reset values: state=IDLE, every *_vld_r/_r output 0, stk_cmd_clr_r=0, done_r=0, err_r=0, data regs 0.
- All outputs are registered. The stack observes a command on the cycle after it is issued, and presents stk_head_vld_r two cycles after that.
- FSM states: IDLE, PUSH, POP, POP_WAIT, ISSUE, WAIT_RES, SPLIT, DONE, ERR.
- IDLE:
  - start_vld & start_rdy accepts the request and clears err_r.
  - If start_hi<=start_lo: go to DONE; no job and no stack command.
  - Otherwise push {start_lo,start_hi} and go to POP.
- POP:
  - Entered only when no stack command is in flight.
  - stk_empty_w=1 goes to DONE.
  - Otherwise issue a one-cycle pop and go to POP_WAIT.
- POP_WAIT: hold until stk_head_vld_r, latch job_lo_r/job_hi_r from stk_head_r, go to ISSUE.
- ISSUE:
  - Assert job_vld_r and hold job_* stable until job_rdy; standard valid/ready, no retraction.
  - On the handshake, drop job_vld_r and go to WAIT_RES.
- WAIT_RES: on res_vld, latch res_pivot as p and go to SPLIT. res_vld outside WAIT_RES is ignored.
- SPLIT:
  - Left range {lo,p-1} is valid iff p>=lo+2. Right range {p+1,hi} is valid iff hi>=p+2.
  - Compare in AW+1 bits so no underflow or overflow occurs at p=0 or p=N-1.
  - Push right first, then left, one push per cycle, so left is processed first.
  - Then go to POP. If neither range is valid, go straight to POP.
- Push while stk_full_w=1:
  - The push is not issued.
  - Go to ERR: set err_r, pulse stk_cmd_clr_r for one cycle, go to IDLE with no done_r.
- stk_cmd_err_w=1 in any state: go to ERR (same action).
- DONE: done_r=1 for exactly one cycle, then IDLE.
- At most one stack command is in flight. stk_cmd_vld_r is never high on two consecutive cycles with a pop pending.
- start_vld is ignored outside IDLE.
- Asserting rst in any state returns every output to its reset value asynchronously. The stack shares rst, so no clear is needed.

Decomposition:
- qs_pkg holds:
  - addr_t (AW bits)
  - range_t packed struct {lo,hi}, with $bits equal to W
  - the ctrl_state_t enum
  - a range_valid(lo,hi) function (hi>=lo+1)
- No sub-module: the split logic is a few comparators and stays inline.
- The stack is instantiated beside this block in the parent qs_srt.

Test Plan:
- start lo=3 hi=3 -> done_r one cycle after accept; no job_vld_r, no stk_cmd_vld_r.
- start 0..7, pivot 3 -> job[0,7], then pushes [4,7] then [0,2], next job [0,2].
- start 0..7, pivot 0 -> only [1,7] pushed. Then pivot 7 on [1,7] -> only [1,6] pushed; no underflow or overflow.
- STACK_N=2, start 0..15, pivots always mid -> third outstanding push sees stk_full_w; err_r=1, one-cycle stk_cmd_clr_r, IDLE, no done_r.
- job_rdy low 5 cycles in ISSUE -> job_vld_r/job_lo_r/job_hi_r stable; one job accepted when job_rdy rises.
- rst asserted mid WAIT_RES -> all outputs at reset values immediately. A new start 0..1 then completes with one job and done_r.
